// File: rtl/input_dot_engine.sv
// Dot-product sequencer: streams a sample vector and its weights out of two read-only
// buffers, multiplies and accumulates with saturation, and emits one result per start.
module input_dot_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH:0]          vec_len,
  output logic                         in_rd_en,
  output logic [ADDR_WIDTH-1:0]        in_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] in_rd_data,
  output logic                         w_rd_en,
  output logic [ADDR_WIDTH-1:0]        w_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] w_rd_data,
  output logic                         busy,
  output logic signed [ACC_WIDTH-1:0]  result,
  output logic                         result_valid,
  output logic                         sat
);

  localparam int PW  = 2 * DATA_WIDTH;
  localparam int EXT = ACC_WIDTH + 1 - PW;
  localparam logic [ADDR_WIDTH:0]    LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]    CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ACC_WIDTH-1:0]   ACC_ZERO = {ACC_WIDTH{1'b0}};
  localparam logic [ACC_WIDTH-1:0]   ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0]   ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [PW-1:0]          PROD_ZERO = {PW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic                   drain_r;
  logic [ADDR_WIDTH-1:0]  base_r;
  logic [ADDR_WIDTH:0]    len_r, cnt_r;
  logic                   rd_en_r;
  logic [ADDR_WIDTH-1:0]  in_addr_r, w_addr_r;
  logic                   dv_r, pv_r;
  logic [PW-1:0]          prod_r;
  logic [ACC_WIDTH-1:0]   acc_r;
  logic                   sat_acc_r;
  logic                   busy_r, valid_r, sat_r;
  logic [ACC_WIDTH-1:0]   result_r;

  logic                   accept_s, abort_s, last_s;
  logic [PW-1:0]          in_ext_s, w_ext_s, prod_s;
  logic [ACC_WIDTH:0]     sum_s;
  logic [ACC_WIDTH-1:0]   acc_nxt_s;
  logic                   ovf_s;

  assign accept_s = (state_r == S_IDLE) && start && !abort;
  assign abort_s  = (state_r != S_IDLE) && abort;
  assign last_s   = (cnt_r == len_r);

  // Low PW bits of the widened product equal the signed full-precision product.
  assign in_ext_s = {{DATA_WIDTH{in_rd_data[DATA_WIDTH-1]}}, in_rd_data};
  assign w_ext_s  = {{DATA_WIDTH{w_rd_data[DATA_WIDTH-1]}}, w_rd_data};
  assign prod_s   = in_ext_s * w_ext_s;
  assign sum_s    = {acc_r[ACC_WIDTH-1], acc_r} + {{EXT{prod_r[PW-1]}}, prod_r};

  // Saturating accumulate: one guard bit exposes signed overflow.
  always_comb begin
    acc_nxt_s = sum_s[ACC_WIDTH-1:0];
    ovf_s     = 1'b0;
    if (sum_s[ACC_WIDTH] != sum_s[ACC_WIDTH-1]) begin
      ovf_s     = 1'b1;
      acc_nxt_s = sum_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      ovf_s     = 1'b0;
      acc_nxt_s = sum_s[ACC_WIDTH-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = (vec_len == LEN_ZERO) ? S_FLUSH : S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (abort_s) begin
          state_s = S_IDLE;
        end else if (last_s) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (abort_s) begin
          state_s = S_IDLE;
        end else if (drain_r) begin
          state_s = S_FLUSH;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_FLUSH: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register; drain_r marks the second DRAIN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      drain_r <= 1'b0;
    end else begin
      state_r <= state_s;
      drain_r <= (state_r == S_DRAIN);
    end
  end

  // Read sequencing, MAC pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r    <= ADDR_ZERO;
      len_r     <= LEN_ZERO;
      cnt_r     <= LEN_ZERO;
      rd_en_r   <= 1'b0;
      in_addr_r <= ADDR_ZERO;
      w_addr_r  <= ADDR_ZERO;
      dv_r      <= 1'b0;
      pv_r      <= 1'b0;
      prod_r    <= PROD_ZERO;
      acc_r     <= ACC_ZERO;
      sat_acc_r <= 1'b0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      sat_r     <= 1'b0;
      result_r  <= ACC_ZERO;
    end else begin
      valid_r <= 1'b0;
      if (abort_s) begin
        rd_en_r <= 1'b0;
        dv_r    <= 1'b0;
        pv_r    <= 1'b0;
        busy_r  <= 1'b0;
      end else if (accept_s) begin
        base_r    <= base_addr;
        len_r     <= vec_len;
        acc_r     <= ACC_ZERO;
        prod_r    <= PROD_ZERO;
        dv_r      <= 1'b0;
        pv_r      <= 1'b0;
        sat_acc_r <= 1'b0;
        busy_r    <= 1'b1;
        if (vec_len != LEN_ZERO) begin
          rd_en_r   <= 1'b1;
          in_addr_r <= base_addr;
          w_addr_r  <= ADDR_ZERO;
          cnt_r     <= CNT_ONE;
        end else begin
          rd_en_r <= 1'b0;
          cnt_r   <= LEN_ZERO;
        end
      end else begin
        dv_r <= rd_en_r;
        pv_r <= dv_r;
        if (dv_r) begin
          prod_r <= prod_s;
        end
        if (pv_r) begin
          acc_r     <= acc_nxt_s;
          sat_acc_r <= sat_acc_r | ovf_s;
        end
        if (state_r == S_FETCH) begin
          if (last_s) begin
            rd_en_r <= 1'b0;
          end else begin
            in_addr_r <= base_r + cnt_r[ADDR_WIDTH-1:0];
            w_addr_r  <= cnt_r[ADDR_WIDTH-1:0];
            cnt_r     <= cnt_r + CNT_ONE;
          end
        end
        if (state_r == S_FLUSH) begin
          result_r <= acc_r;
          sat_r    <= sat_acc_r;
          valid_r  <= 1'b1;
        end
        // Busy covers the result cycle so the next start lands after the pulse.
        busy_r <= (state_s != S_IDLE) || (state_r == S_FLUSH);
      end
    end
  end

  assign in_rd_en     = rd_en_r;
  assign w_rd_en      = rd_en_r;
  assign in_rd_addr   = in_addr_r;
  assign w_rd_addr    = w_addr_r;
  assign busy         = busy_r;
  assign result       = result_r;
  assign result_valid = valid_r;
  assign sat          = sat_r;

endmodule

// File: tb/tb_input_dot_engine.sv
// Randomized self-checking bench for input_dot_engine against a plain-arithmetic dot-product model.
module tb_input_dot_engine;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam int MAX_CYC = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic [8:0] vec_len = 9'd0;
  logic in_rd_en, w_rd_en;
  logic [7:0] in_rd_addr, w_rd_addr;
  logic signed [15:0] in_rd_data = 16'sd0;
  logic signed [15:0] w_rd_data = 16'sd0;
  logic busy, result_valid, sat;
  logic signed [31:0] result;

  logic signed [15:0] in_mem [256];
  logic signed [15:0] w_mem [256];

  int total = 0;
  int bad = 0;

  int n_reads, n_valid, valid_edge, busy_fall, first_en, last_en;
  logic signed [31:0] v_result;
  logic v_sat;
  int in_q[$];
  int w_q[$];
  logic signed [31:0] last_result = 32'sd0;
  logic last_sat = 1'b0;

  input_dot_engine #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .ACC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .vec_len(vec_len),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .busy(busy), .result(result), .result_valid(result_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  // Buffer models: one-cycle read latency.
  always @(posedge clk) begin
    if (in_rd_en) in_rd_data <= in_mem[in_rd_addr];
    if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic ref_dot(input int base, input int len, output logic signed [31:0] r, output logic s);
    longint acc = 0;
    s = 1'b0;
    for (int k = 0; k < len; k++) begin
      acc = acc + longint'(in_mem[(base + k) % 256]) * longint'(w_mem[k]);
      if (acc > MAXV) begin acc = MAXV; s = 1'b1; end
      else if (acc < MINV) begin acc = MINV; s = 1'b1; end
    end
    r = 32'(acc);
  endtask

  // Launches one operation and records what the DUT does edge by edge.
  task automatic do_run(input int base, input int len, input int abort_e, input int glitch_e);
    n_reads = 0; n_valid = 0; valid_edge = -1; busy_fall = -1; first_en = -1; last_en = -1;
    in_q.delete(); w_q.delete();
    @(negedge clk);
    base_addr = 8'(base); vec_len = 9'(len); start = 1'b1;
    for (int e = 0; e < MAX_CYC; e++) begin
      @(negedge clk);
      start = (e == glitch_e);
      if (e == glitch_e) begin base_addr = 8'($urandom); vec_len = 9'd3; end
      abort = (e == abort_e);
      if (in_rd_en) begin
        n_reads++;
        if (first_en < 0) first_en = e;
        last_en = e;
        in_q.push_back(int'(in_rd_addr));
        w_q.push_back(int'(w_rd_addr));
      end
      if (result_valid) begin n_valid++; valid_edge = e; v_result = result; v_sat = sat; end
      if (!busy) begin busy_fall = e; break; end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (in_rd_en !== 1'b0 || w_rd_en !== 1'b0) begin bad++; $display("FAIL reset_en: got %b/%b want 0/0", in_rd_en, w_rd_en); end
    total++; if (in_rd_addr !== 8'd0 || w_rd_addr !== 8'd0) begin bad++; $display("FAIL reset_addr: got %0d/%0d want 0/0", in_rd_addr, w_rd_addr); end
    total++; if (busy !== 1'b0 || result_valid !== 1'b0) begin bad++; $display("FAIL reset_busy_valid: got %b/%b want 0/0", busy, result_valid); end
    total++; if (result !== 32'sd0 || sat !== 1'b0) begin bad++; $display("FAIL reset_result: got %0d sat %b want 0 sat 0", result, sat); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || in_rd_en !== 1'b0) begin bad++; $display("FAIL reset_release: busy %b en %b want 0 0", busy, in_rd_en); end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 4; i++) begin
      in_mem[i] = 16'(i + 1);
      w_mem[i] = 16'(i + 5);
    end
  endtask

  task automatic test_basic();
    load_basic();
    do_run(0, 4, -1, -1);
    total++; if (v_result !== 32'sd70 || v_sat !== 1'b0) begin bad++; $display("FAIL basic_result: got %0d sat %b want 70 sat 0", v_result, v_sat); end
    total++; if (valid_edge !== 7 || n_valid !== 1) begin bad++; $display("FAIL basic_valid: edge %0d count %0d want 7 1", valid_edge, n_valid); end
    total++; if (n_reads !== 4 || first_en !== 0 || last_en !== 3) begin bad++; $display("FAIL basic_reads: n %0d first %0d last %0d want 4 0 3", n_reads, first_en, last_en); end
    total++; if (busy_fall !== 8) begin bad++; $display("FAIL basic_busy: fell at %0d want 8", busy_fall); end
    last_result = 32'sd70; last_sat = 1'b0;
  endtask

  task automatic test_wrap();
    logic signed [31:0] er; logic es;
    int exp_in[4] = '{254, 255, 0, 1};
    for (int i = 0; i < 256; i++) begin in_mem[i] = 16'($urandom); w_mem[i] = 16'($urandom); end
    ref_dot(254, 4, er, es);
    do_run(254, 4, -1, -1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (in_q.size() <= k || in_q[k] !== exp_in[k] || w_q[k] !== k) begin
        bad++; $display("FAIL wrap_addr[%0d]: got %0d/%0d want %0d/%0d", k, (in_q.size() > k) ? in_q[k] : -1, (w_q.size() > k) ? w_q[k] : -1, exp_in[k], k);
      end
    end
    total++; if (v_result !== er || v_sat !== es) begin bad++; $display("FAIL wrap_result: got %0d sat %b want %0d sat %b", v_result, v_sat, er, es); end
    last_result = er; last_sat = es;
  endtask

  task automatic test_saturation();
    logic signed [31:0] er; logic es;
    int base = $urandom_range(1, 255);
    for (int i = 0; i < 256; i++) begin in_mem[i] = -16'sd32768; w_mem[i] = -16'sd32768; end
    do_run(base, 256, -1, -1);
    total++; if (v_result !== 32'sh7fffffff || v_sat !== 1'b1) begin bad++; $display("FAIL sat_clamp: got %0d sat %b want 2147483647 sat 1", v_result, v_sat); end
    total++; if (n_reads !== 256 || in_q[255] !== (base + 255) % 256) begin bad++; $display("FAIL sat_reads: n %0d last %0d want 256 %0d", n_reads, in_q[n_reads > 0 ? n_reads - 1 : 0], (base + 255) % 256); end
    total++; if (valid_edge !== 259 || busy_fall !== 260) begin bad++; $display("FAIL sat_timing: valid %0d busy %0d want 259 260", valid_edge, busy_fall); end
    for (int i = 0; i < 8; i++) begin in_mem[i] = 16'(i - 3); w_mem[i] = 16'(2 * i + 1); end
    ref_dot(0, 8, er, es);
    do_run(0, 8, -1, -1);
    total++; if (v_result !== er || v_sat !== 1'b0) begin bad++; $display("FAIL sat_clear: got %0d sat %b want %0d sat 0", v_result, v_sat, er); end
    last_result = er; last_sat = 1'b0;
  endtask

  task automatic test_zero_len();
    do_run($urandom_range(0, 255), 0, -1, -1);
    total++; if (v_result !== 32'sd0 || v_sat !== 1'b0 || n_valid !== 1) begin bad++; $display("FAIL zero_result: got %0d sat %b n %0d want 0 0 1", v_result, v_sat, n_valid); end
    total++; if (valid_edge !== 1 || busy_fall !== 2 || n_reads !== 0) begin bad++; $display("FAIL zero_timing: valid %0d busy %0d reads %0d want 1 2 0", valid_edge, busy_fall, n_reads); end
    last_result = 32'sd0; last_sat = 1'b0;
  endtask

  task automatic test_random();
    logic signed [31:0] er; logic es;
    int base, len;
    for (int it = 0; it < 20; it++) begin
      base = $urandom_range(0, 255);
      len = (it == 0) ? 1 : $urandom_range(0, 256);
      for (int i = 0; i < 256; i++) begin in_mem[i] = 16'($urandom); w_mem[i] = 16'($urandom); end
      ref_dot(base, len, er, es);
      do_run(base, len, -1, -1);
      total++;
      if (v_result !== er || v_sat !== es || n_valid !== 1) begin
        bad++; $display("FAIL rand_result[%0d]: got %0d sat %b n %0d want %0d sat %b n 1", it, v_result, v_sat, n_valid, er, es);
      end
      total++;
      if (n_reads !== len || valid_edge !== ((len == 0) ? 1 : len + 3) || busy_fall !== ((len == 0) ? 2 : len + 4)) begin
        bad++; $display("FAIL rand_timing[%0d]: len %0d reads %0d valid %0d busy %0d", it, len, n_reads, valid_edge, busy_fall);
      end
      last_result = er; last_sat = es;
    end
  endtask

  task automatic test_start_ignored();
    logic signed [31:0] er; logic es;
    for (int i = 0; i < 256; i++) begin in_mem[i] = 16'($urandom); w_mem[i] = 16'($urandom); end
    ref_dot(10, 8, er, es);
    do_run(10, 8, -1, 3);
    total++; if (v_result !== er || v_sat !== es) begin bad++; $display("FAIL glitch_result: got %0d sat %b want %0d sat %b", v_result, v_sat, er, es); end
    total++; if (n_reads !== 8 || valid_edge !== 11 || n_valid !== 1) begin bad++; $display("FAIL glitch_timing: reads %0d valid %0d n %0d want 8 11 1", n_reads, valid_edge, n_valid); end
    last_result = er; last_sat = es;
  endtask

  task automatic test_abort();
    logic signed [31:0] er; logic es;
    do_run(20, 8, 2, -1);
    total++; if (busy_fall !== 3 || n_valid !== 0 || n_reads !== 3) begin bad++; $display("FAIL abort_timing: busy %0d valid %0d reads %0d want 3 0 3", busy_fall, n_valid, n_reads); end
    total++; if (result !== last_result || sat !== last_sat) begin bad++; $display("FAIL abort_hold: got %0d sat %b want %0d sat %b", result, sat, last_result, last_sat); end
    ref_dot(30, 5, er, es);
    do_run(30, 5, -1, -1);
    total++; if (v_result !== er || v_sat !== es) begin bad++; $display("FAIL abort_next: got %0d sat %b want %0d sat %b", v_result, v_sat, er, es); end
    last_result = er; last_sat = es;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    base_addr = 8'd0; vec_len = 9'd8; start = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    total++; if (in_rd_en !== 1'b0 || w_rd_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_ctrl: en %b/%b busy %b want 0", in_rd_en, w_rd_en, busy); end
    total++; if (result !== 32'sd0 || sat !== 1'b0 || in_rd_addr !== 8'd0 || w_rd_addr !== 8'd0) begin bad++; $display("FAIL midrst_data: result %0d sat %b addr %0d/%0d want 0", result, sat, in_rd_addr, w_rd_addr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_novalid: saw %0d pulses want 0", seen); end
    load_basic();
    do_run(0, 4, -1, -1);
    total++; if (v_result !== 32'sd70 || v_sat !== 1'b0 || valid_edge !== 7) begin bad++; $display("FAIL midrst_restart: got %0d sat %b edge %0d want 70 0 7", v_result, v_sat, valid_edge); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin in_mem[i] = 16'sd0; w_mem[i] = 16'sd0; end
    test_reset();
    test_basic();
    test_wrap();
    test_saturation();
    test_zero_len();
    test_random();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_dot_engine.md
# input_dot_engine

Sequencer and multiply-accumulate stage that sits directly downstream of the input buffer. On `start` it reads a vector of signed samples from the input buffer and the matching weights from a weight buffer. It multiplies each sample by its weight and accumulates the products. It then presents one saturated dot-product result with a single-cycle valid pulse. It drives the read ports of both buffers; neither buffer is written by this block.

## Interface
- `DATA_WIDTH`, default 16: signed sample and weight width.
- `ADDR_WIDTH`, default 8: buffer address width; vectors hold up to 2^ADDR_WIDTH entries.
- `ACC_WIDTH`, default 40: signed accumulator and result width; must be at least 2*DATA_WIDTH.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: launch request; honoured only in IDLE.
- `abort` in 1: cancel the operation in progress.
- `base_addr` in ADDR_WIDTH: first input-buffer address; latched on an accepted start.
- `vec_len` in ADDR_WIDTH+1: number of elements, 0..2^ADDR_WIDTH; latched on an accepted start.
- `in_rd_en` out 1: input-buffer read enable.
- `in_rd_addr` out ADDR_WIDTH: input-buffer read address.
- `in_rd_data` in DATA_WIDTH, signed: input-buffer data; valid the cycle after `in_rd_en`.
- `w_rd_en` out 1: weight-buffer read enable.
- `w_rd_addr` out ADDR_WIDTH: weight index.
- `w_rd_data` in DATA_WIDTH, signed: weight data; same one-cycle latency as `in_rd_data`.
- `busy` out 1: high in any state other than IDLE.
- `result` out ACC_WIDTH, signed: dot product; held until the next `result_valid`.
- `result_valid` out 1: one-cycle pulse.
- `sat` out 1: the accumulator saturated during this result; valid with `result_valid` and held alongside `result`.

## Operation
- States and transitions:
  - IDLE -> FETCH on `start` when `vec_len` != 0.
  - IDLE -> FLUSH on `start` when `vec_len` == 0.
  - FETCH -> DRAIN after the last read has been issued.
  - DRAIN -> FLUSH after two cycles.
  - FLUSH -> IDLE after one cycle.
- Accepted start:
  - Latch `base_addr` and `vec_len`.
  - Clear the element index, the accumulator, the product register, the data-valid pipeline and the internal saturation flag.
  - `start` while `busy` is ignored and does not alter the latched values.
- FETCH, at element index k = 0..len-1:
  - `in_rd_en` = `w_rd_en` = 1.
  - `in_rd_addr` = (base + k) mod 2^ADDR_WIDTH; wrap past the top address is legal.
  - `w_rd_addr` = k.
- Pipeline:
  - A valid flag follows each read by one cycle.
  - Stage 1 registers the full-precision signed product `in_rd_data` * `w_rd_data` (2*DATA_WIDTH bits).
  - Stage 2 sign-extends the product and adds it into the accumulator.
- Saturation:
  - If a stage-2 sum exceeds the ACC_WIDTH signed range, clamp the accumulator to max or min and set the internal saturation flag.
  - The flag is sticky until the next accepted start.
  - Later products continue adding from the clamped value.
- FLUSH:
  - `result` <= accumulator, `sat` <= internal saturation flag, `result_valid` = 1 for one cycle.
  - For `vec_len` = 0: `result` = 0, `sat` = 0, no buffer reads.
- `abort`, in any non-IDLE state:
  - Next edge returns to IDLE and drops the read enables.
  - No `result_valid`; `result` and `sat` keep their previous values; the pipeline is flushed.
- `abort` and `start` together in IDLE: abort wins and the start is ignored.

## Timing
- Edge 0 is the rising edge that samples an accepted `start`.
- `in_rd_en`/`w_rd_en` are high from edge 0 until edge len: exactly `vec_len` consecutive cycles, one element per cycle, no bubbles.
- Element k: data is present after edge k+1, the product is registered at edge k+2, and it is accumulated at edge k+3.
- `result_valid` rises at edge len+3 and falls at edge len+4.
- `busy` falls at edge len+4, so the next start can be sampled at edge len+4.
- For `vec_len` = 0: `result_valid` is high from edge 1 to edge 2.
- Reset: all of the following are 0, state is IDLE and the pipeline is cleared:
  - `in_rd_en`, `w_rd_en`, `in_rd_addr`, `w_rd_addr`
  - `busy`, `result`, `result_valid`, `sat`
- Reset asserted mid-operation: no result is produced.

## Test plan
- `base_addr`=0, `vec_len`=4, inputs 1,2,3,4, weights 5,6,7,8 -> `result`=70, `sat`=0; `result_valid` only at edge 7; exactly 4 read-enable cycles.
- `base_addr`=254, `vec_len`=4, ADDR_WIDTH=8 -> `in_rd_addr` sequence 254,255,0,1 and `w_rd_addr` sequence 0,1,2,3; result matches the software model.
- Inputs -32768, weights -32768, `vec_len`=256, ACC_WIDTH=32 -> accumulator clamps to 2^31-1 and `sat`=1; the next start with small data gives `sat`=0.
- `vec_len`=0 -> `result`=0 and `result_valid` at edge 1 with no read enables; `vec_len`=256 -> 256 reads, last `in_rd_addr` = base-1 mod 256.
- `start` pulsed during FETCH -> ignored and the result is unchanged. `abort` at edge 2 of a length-8 run -> IDLE at edge 3, no `result_valid`, prior `result` kept.
- `rst_n` low at edge 3 of a length-8 run -> all outputs 0 immediately. Restart after release with the vector from the first test -> `result`=70.
